// File: rtl/wfifo_pkg.sv
// rtl/wfifo_pkg.sv - shared defaults, level-width helper and weight type for the weight FIFO bank
package wfifo_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 16;
   localparam int DEF_LANES  = 4;

   typedef logic [DEF_DATA_W-1:0] weight_t;

   // Occupancy must represent 0..depth inclusive, hence one bit more than the pointer.
   function automatic int lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/wfifo_lane.sv
// rtl/wfifo_lane.sv - one weight FIFO lane: storage, pointers, occupancy, push handshake, push_err
module wfifo_lane import wfifo_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_valid,
   input  logic [DATA_W-1:0]        push_data,
   output logic                     push_ready,
   input  logic                     pop,
   output logic [DATA_W-1:0]        rd_data,
   output logic [lvl_w(DEPTH)-1:0]  level,
   output logic                     push_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = lvl_w(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              wr_en;

   assign push_ready = (level != LW'(DEPTH));
   assign wr_en      = push_valid && push_ready;
   assign rd_data    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst && wr_en) mem[wr_ptr] <= push_data;
   end

   // pop is already qualified by the bank; full/empty come from level only.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         push_err <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         if (push_valid && !push_ready) push_err <= 1'b1;
         case ({wr_en, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/weight_fifo_bank.sv
// rtl/weight_fifo_bank.sv - multi-lane weight staging FIFO with row-wide pop
// Optional WFIFO_SKEW_EN: lane i output delayed i extra cycles (diagonal systolic stagger).
module weight_fifo_bank import wfifo_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int LANES  = DEF_LANES
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [LANES-1:0]                push_valid,
   input  logic [LANES*DATA_W-1:0]         push_data,
   output logic [LANES-1:0]                push_ready,
   input  logic                            pop,
   output logic                            pop_ready,
   output logic [LANES*DATA_W-1:0]         data_out,
   output logic [LANES-1:0]                out_valid,
   output logic [LANES*lvl_w(DEPTH)-1:0]   level,
   output logic [LANES-1:0]                push_err,
   output logic                            pop_err
);
   localparam int LW = lvl_w(DEPTH);

   logic [LANES*DATA_W-1:0] rd_data;
   logic [LANES-1:0]        nonempty;
   logic                    pop_acc;
   logic [LANES*DATA_W-1:0] row_q;
   logic [LANES-1:0]        vld_q;

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      wfifo_lane #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane (
         .clk        (clk),
         .rst        (rst),
         .push_valid (push_valid[gi]),
         .push_data  (push_data[gi*DATA_W +: DATA_W]),
         .push_ready (push_ready[gi]),
         .pop        (pop_acc),
         .rd_data    (rd_data[gi*DATA_W +: DATA_W]),
         .level      (level[gi*LW +: LW]),
         .push_err   (push_err[gi])
      );
      assign nonempty[gi] = |level[gi*LW +: LW];
   end

   assign pop_ready = &nonempty;
   assign pop_acc   = pop && pop_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         row_q   <= '0;
         vld_q   <= '0;
         pop_err <= 1'b0;
      end else begin
         vld_q <= {LANES{pop_acc}};
         if (pop_acc) row_q <= rd_data;
         if (pop && !pop_ready) pop_err <= 1'b1;
      end
   end

`ifdef WFIFO_SKEW_EN
   for (genvar gi = 0; gi < LANES; gi++) begin : g_skew
      if (gi == 0) begin : g_direct
         assign data_out[0 +: DATA_W] = row_q[0 +: DATA_W];
         assign out_valid[0]          = vld_q[0];
      end else begin : g_delay
         logic [DATA_W-1:0] d_sr [gi];
         logic              v_sr [gi];
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int k = 0; k < gi; k++) begin
                  d_sr[k] <= '0;
                  v_sr[k] <= 1'b0;
               end
            end else begin
               d_sr[0] <= row_q[gi*DATA_W +: DATA_W];
               v_sr[0] <= vld_q[gi];
               for (int k = 1; k < gi; k++) begin
                  d_sr[k] <= d_sr[k-1];
                  v_sr[k] <= v_sr[k-1];
               end
            end
         end
         assign data_out[gi*DATA_W +: DATA_W] = d_sr[gi-1];
         assign out_valid[gi]                 = v_sr[gi-1];
      end
   end
`else
   assign data_out  = row_q;
   assign out_valid = vld_q;
`endif

endmodule

// File: tb/tb_weight_fifo_bank.sv
// tb/tb_weight_fifo_bank.sv - directed self-checking bench for weight_fifo_bank (default 8x16x4)
module tb_weight_fifo_bank;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  push_valid;
   logic [31:0] push_data;
   logic [3:0]  push_ready;
   logic        pop;
   logic        pop_ready;
   logic [31:0] data_out;
   logic [3:0]  out_valid;
   logic [19:0] level;
   logic [3:0]  push_err;
   logic        pop_err;

   int total = 0;
   int bad   = 0;

   weight_fifo_bank dut (
      .clk(clk), .rst(rst), .push_valid(push_valid), .push_data(push_data),
      .push_ready(push_ready), .pop(pop), .pop_ready(pop_ready), .data_out(data_out),
      .out_valid(out_valid), .level(level), .push_err(push_err), .pop_err(pop_err)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] lvl(input int i);
      return level[i*5 +: 5];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; push_valid = '0; push_data = '0; pop = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (level !== 20'd0) begin bad++; $display("FAIL reset_level got=%h exp=0", level); end
      total++; if (push_ready !== 4'hF) begin bad++; $display("FAIL reset_push_ready got=%h exp=f", push_ready); end
      total++; if (pop_ready !== 1'b0) begin bad++; $display("FAIL reset_pop_ready got=%b exp=0", pop_ready); end
      total++; if (data_out !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", data_out); end
      total++; if (out_valid !== 4'h0) begin bad++; $display("FAIL reset_out_valid got=%h exp=0", out_valid); end
      total++; if ({push_err, pop_err} !== 5'd0) begin bad++; $display("FAIL reset_err got=%h exp=0", {push_err, pop_err}); end
   endtask

   task automatic test_basic_row();
      do_reset();
      push_valid = 4'hF; push_data = 32'h44332211;
      step();
      push_valid = '0;
      total++; if (level !== {5'd1, 5'd1, 5'd1, 5'd1}) begin bad++; $display("FAIL basic_level got=%h exp=%h", level, {5'd1, 5'd1, 5'd1, 5'd1}); end
      total++; if (pop_ready !== 1'b1) begin bad++; $display("FAIL basic_pop_ready got=%b exp=1", pop_ready); end
      pop = 1'b1;
      step();
      pop = 1'b0;
      total++; if (data_out !== 32'h44332211) begin bad++; $display("FAIL basic_data got=%h exp=44332211", data_out); end
      total++; if (out_valid !== 4'hF) begin bad++; $display("FAIL basic_valid got=%h exp=f", out_valid); end
      step();
      total++; if (out_valid !== 4'h0) begin bad++; $display("FAIL basic_valid_drop got=%h exp=0", out_valid); end
      total++; if (data_out !== 32'h44332211) begin bad++; $display("FAIL basic_data_hold got=%h exp=44332211", data_out); end
   endtask

   task automatic test_full();
      do_reset();
      for (int k = 0; k < 16; k++) begin
         push_valid = 4'hF; push_data = {4{8'(k + 1)}};
         step();
      end
      push_valid = 4'h1; push_data = 32'h000000AA;
      step();
      push_valid = '0;
      total++; if (push_ready[0] !== 1'b0) begin bad++; $display("FAIL full_push_ready got=%b exp=0", push_ready[0]); end
      total++; if (lvl(0) !== 5'd16) begin bad++; $display("FAIL full_level got=%0d exp=16", lvl(0)); end
      total++; if (push_err !== 4'h1) begin bad++; $display("FAIL full_push_err got=%h exp=1", push_err); end
      pop = 1'b1;
      for (int k = 0; k < 16; k++) begin
         step();
         total++;
         if (data_out[7:0] !== 8'(k + 1)) begin bad++; $display("FAIL full_drain_%0d got=%h exp=%h", k, data_out[7:0], 8'(k + 1)); end
      end
      pop = 1'b0;
      total++; if (pop_ready !== 1'b0 || lvl(0) !== 5'd0) begin bad++; $display("FAIL full_empty got=%b/%0d exp=0/0", pop_ready, lvl(0)); end
      total++; if (pop_err !== 1'b0) begin bad++; $display("FAIL full_pop_err got=%b exp=0", pop_err); end
   endtask

   task automatic test_pop_err();
      do_reset();
      push_valid = 4'h1;
      for (int k = 0; k < 3; k++) begin
         push_data = {24'd0, 8'(8'h50 + k)};
         step();
      end
      push_valid = '0;
      total++; if (pop_ready !== 1'b0) begin bad++; $display("FAIL poperr_pop_ready got=%b exp=0", pop_ready); end
      pop = 1'b1;
      step();
      pop = 1'b0;
      total++; if (pop_err !== 1'b1) begin bad++; $display("FAIL poperr_flag got=%b exp=1", pop_err); end
      total++; if (lvl(0) !== 5'd3) begin bad++; $display("FAIL poperr_level got=%0d exp=3", lvl(0)); end
      total++; if (data_out !== 32'd0 || out_valid !== 4'h0) begin bad++; $display("FAIL poperr_data got=%h/%h exp=0/0", data_out, out_valid); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      for (int k = 0; k < 16; k++) begin
         push_valid = 4'hF; push_data = {4{8'(k)}};
         step();
      end
      push_valid = 4'h1; push_data = 32'h000000BB; pop = 1'b1;
      step();
      push_valid = '0; pop = 1'b0;
      total++; if (lvl(0) !== 5'd15) begin bad++; $display("FAIL simul_full_level got=%0d exp=15", lvl(0)); end
      total++; if (push_ready[0] !== 1'b1) begin bad++; $display("FAIL simul_full_ready got=%b exp=1", push_ready[0]); end
      do_reset();
      push_valid = 4'hE; push_data = 32'h01010100;
      step();
      push_valid = 4'h1; push_data = 32'h000000CC; pop = 1'b1;
      step();
      push_valid = '0; pop = 1'b0;
      total++; if (lvl(0) !== 5'd1) begin bad++; $display("FAIL simul_empty_level got=%0d exp=1", lvl(0)); end
      total++; if (pop_err !== 1'b1) begin bad++; $display("FAIL simul_empty_pop_err got=%b exp=1", pop_err); end
      total++; if (level[19:5] !== {5'd1, 5'd1, 5'd1}) begin bad++; $display("FAIL simul_empty_others got=%h exp=%h", level[19:5], {5'd1, 5'd1, 5'd1}); end
   endtask

   task automatic test_stream();
      logic [7:0] q[$];
      logic [7:0] exp_v;
      logic       acc;
      int sent = 0;
      int got  = 0;
      int cyc  = 0;
      do_reset();
      while (got < 40 && cyc < 300) begin
         push_valid = (sent < 40) ? 4'hF : 4'h0;
         push_data  = {24'h777777, 8'(8'h30 + sent)};
         pop        = pop_ready;
         acc        = push_valid[0] && push_ready[0];
         step();
         if (acc) begin q.push_back(push_data[7:0]); sent++; end
         if (out_valid[0]) begin
            exp_v = (q.size() > 0) ? q.pop_front() : 8'hXX;
            total++;
            if (data_out[7:0] !== exp_v) begin bad++; $display("FAIL stream_%0d got=%h exp=%h", got, data_out[7:0], exp_v); end
            got++;
         end
         cyc++;
      end
      push_valid = '0; pop = 1'b0;
      total++; if (got !== 40) begin bad++; $display("FAIL stream_count got=%0d exp=40", got); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      pop = 1'b1;
      step();
      pop = 1'b0;
      for (int k = 0; k < 8; k++) begin
         push_valid = 4'hF; push_data = {4{8'(8'h90 + k)}};
         step();
      end
      push_valid = '0; pop = 1'b1;
      step();
      total++; if (lvl(0) !== 5'd7 || pop_err !== 1'b1) begin bad++; $display("FAIL mid_pre got=%0d/%b exp=7/1", lvl(0), pop_err); end
      rst = 1'b1; push_valid = 4'hF;
      step();
      rst = 1'b0; pop = 1'b0; push_valid = '0;
      total++; if (level !== 20'd0) begin bad++; $display("FAIL mid_level got=%h exp=0", level); end
      total++; if (data_out !== 32'd0 || out_valid !== 4'h0) begin bad++; $display("FAIL mid_out got=%h/%h exp=0/0", data_out, out_valid); end
      total++; if ({push_err, pop_err} !== 5'd0 || pop_ready !== 1'b0 || push_ready !== 4'hF) begin bad++; $display("FAIL mid_flags got=%h/%b/%h exp=0/0/f", {push_err, pop_err}, pop_ready, push_ready); end
   endtask

`ifdef WFIFO_SKEW_EN
   task automatic test_skew();
      do_reset();
      push_valid = 4'hF; push_data = 32'h44332211;
      step();
      push_valid = '0; pop = 1'b1;
      step();
      pop = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         logic [3:0] exp_v;
         exp_v = (c <= 4) ? 4'(1 << (c - 1)) : 4'h0;
         total++;
         if (out_valid !== exp_v) begin bad++; $display("FAIL skew_valid_c%0d got=%h exp=%h", c, out_valid, exp_v); end
         step();
      end
      total++; if (data_out !== 32'h44332211) begin bad++; $display("FAIL skew_data got=%h exp=44332211", data_out); end
   endtask
`endif

   initial begin
      rst = 1'b1; push_valid = '0; push_data = '0; pop = 1'b0;
      test_reset();
`ifndef WFIFO_SKEW_EN
      test_basic_row();
`else
      test_skew();
`endif
      test_full();
      test_pop_err();
      test_simultaneous();
      test_stream();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/weight_fifo_bank.md
Name: weight_fifo_bank

Overview:
Multi-lane, parametrised weight staging FIFO sitting between the DDR weight loader and the MMU weight-load port.
- One independent FIFO per systolic column (lane), with full/empty/level status and a valid/ready push handshake.
- All lanes drain together on a single pop strobe, so one column-load step always delivers a complete weight row.
- Sticky error flags catch protocol violations.

Parameters:
- DATA_W, 8, bit width of one weight
- DEPTH, 16, entries per lane; power of two, >= 2
- LANES, 4, number of lanes (MMU columns)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- push_valid  in  LANES  per-lane write request
- push_data  in  LANES*DATA_W  per-lane write data; lane i in bits [i*DATA_W +: DATA_W]
- push_ready  out  LANES  per-lane not-full
- pop  in  1  row-read strobe (MMU controller, during en_load_weight)
- pop_ready  out  1  all lanes non-empty
- data_out  out  LANES*DATA_W  registered row output
- out_valid  out  LANES  per-lane output-valid pulse
- level  out  LANES*($clog2(DEPTH)+1)  per-lane occupancy, 0..DEPTH
- push_err  out  LANES  sticky: push_valid while full
- pop_err  out  1  sticky: pop while !pop_ready

Behaviour:
- Single clock domain. Reset is synchronous and active-high, sampled on the clk rising edge and overriding all other inputs.
- Reset values:
  - pointers 0, level 0, data_out 0, out_valid 0, push_err 0, pop_err 0
  - push_ready all 1, pop_ready 0
  - storage contents are don't-care
- Push handshake, per lane:
  - push_ready[i] = (level[i] != DEPTH), combinational from registered state.
  - A write occurs when push_valid[i] && push_ready[i]. The data is stored at wr_ptr and wr_ptr increments, wrapping modulo DEPTH.
  - push_valid while full: the write is dropped, state is unchanged, and push_err[i] is set.
- Pop:
  - pop_ready = AND over all lanes of (level != 0).
  - pop && pop_ready: every lane reads mem[rd_ptr] into its data_out slice and rd_ptr increments with wrap.
  - out_valid is all ones on the following cycle only, so latency is 1 cycle.
  - pop && !pop_ready: no lane advances, data_out holds, out_valid = 0, pop_err is set.
- data_out holds its last value whenever no accepted pop occurs.
- Level update per lane: +1 on accepted push only, -1 on accepted pop only, unchanged on both or neither.
- Simultaneous push and pop on the same lane:
  - When full: push_ready is low, so the push is refused and the pop proceeds. Level goes to DEPTH-1 and push_ready rises next cycle.
  - When empty: pop_ready is low. The push is accepted, the pop is refused, and pop_err is set. There is no write-through bypass.
- Pointer wrap: DEPTH is a power of two, so pointers are $clog2(DEPTH) bits and roll over naturally. Full/empty come from level, never from pointer compare.
- Reset mid-operation: all in-flight contents are discarded and the block is in the reset state the next cycle. A pop in the reset cycle produces no out_valid.
- Error flags clear only on rst.

Optional Feature:
Macro: WFIFO_SKEW_EN
- Defined:
  - Lane i's data_out and out_valid pass through an extra i-stage register delay line, so lane i emits i cycles after lane 0. This diagonal stagger matches systolic injection.
  - Pop latency is 1+i for lane i.
  - The delay lines reset to 0.
  - pop_ready is unchanged.
- Undefined: all lanes are aligned with 1-cycle latency, as above.

Decomposition:
- Package wfifo_pkg:
  - default DATA_W/DEPTH/LANES localparams
  - function lvl_w(depth) returning $clog2(depth)+1
  - typedef weight_t (logic [DATA_W-1:0])
- Sub-module wfifo_lane: one FIFO lane (storage, pointers, level, push handshake, push_err). It is instantiated LANES times in a generate loop.
- Top level owns pop_ready aggregation, the pop_err flag, the output registers and the optional skew lines.

Test Plan:
- Reset, then push lane0..3 with 0x11, 0x22, 0x33, 0x44, then pop -> next cycle data_out = {0x44,0x33,0x22,0x11}, out_valid = 4'hF, then 0 the following cycle.
- Fill lane 0 with DEPTH=16 pushes, then push 0xAA -> push_ready[0] = 0, level[0] = 16, push_err[0] = 1, 0xAA never appears on pop.
- Lanes 1..3 empty, lane 0 holding 3 entries, pop -> pop_ready = 0, pop_err = 1, level[0] stays 3, data_out unchanged.
- Lane full, simultaneous push and pop -> level 15, push refused; next cycle push_ready = 1. Empty lane, simultaneous push and pop -> level 1, pop_err = 1.
- Push 40 values through lane 0 in a streaming pattern -> pointer wrap; output order matches input exactly, with no loss or duplication.
- Assert rst mid-stream with level = 7 -> next cycle level = 0, data_out = 0, flags clear. Under WFIFO_SKEW_EN, one pop -> lane i out_valid asserts at cycle 1+i.
